// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_boot_loader
// Description : Byte-stream loader for the core's instruction memory; holds
//               the core in reset until a checksummed load completes.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [2:0] c_s_idle   = 3'd0;
    localparam logic [2:0] c_s_len_hi = 3'd1;
    localparam logic [2:0] c_s_len_lo = 3'd2;
    localparam logic [2:0] c_s_data   = 3'd3;
    localparam logic [2:0] c_s_csum   = 3'd4;
    localparam logic [2:0] c_s_run    = 3'd5;
    localparam logic [2:0] c_s_err    = 3'd6;

    localparam int                 c_tmo_w     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_tmo_w-1:0] c_tmo_last  = c_tmo_w'(TIMEOUT_CYC - 1);
    localparam logic [c_tmo_w-1:0] c_tmo_one   = c_tmo_w'(1);
    localparam logic [32:0]        c_max_words = 33'd1 << ADDR_W;
    localparam logic [ADDR_W:0]    c_wl_one    = (ADDR_W + 1)'(1);

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [7:0]         r_len_hi;
    logic [ADDR_W:0]    r_len;
    logic [23:0]        r_shift;
    logic [1:0]         r_byte_idx;
    logic [7:0]         r_csum;
    logic [c_tmo_w-1:0] r_tmo;

    logic               w_accept;
    logic               w_in_load;
    logic               w_tmo_hit;
    logic [32:0]        w_len;
    logic               w_len_bad;
    logic [ADDR_W:0]    w_wl_inc;
    logic               w_word_done;
    logic               w_last_word;
    logic [7:0]         w_csum_sum;
    logic               w_nxt_load;

    always_comb begin
        w_accept    = in_valid & in_ready;
        w_in_load   = (r_state == c_s_len_hi) || (r_state == c_s_len_lo) ||
                      (r_state == c_s_data)   || (r_state == c_s_csum);
        // An accepted byte always beats an expiring idle counter
        w_tmo_hit   = w_in_load && !w_accept && (r_tmo == c_tmo_last);
        w_len       = {17'd0, r_len_hi, in_data};
        w_len_bad   = (w_len == 33'd0) || (w_len > c_max_words);
        w_wl_inc    = words_loaded + c_wl_one;
        w_word_done = (r_byte_idx == 2'd3);
        w_last_word = (w_wl_inc == r_len);
        w_csum_sum  = r_csum + in_data;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_s_idle, c_s_run, c_s_err: begin
                if (start) begin
                    w_state_nxt = c_s_len_hi;
                end
            end
            c_s_len_hi: begin
                if (w_accept) begin
                    w_state_nxt = c_s_len_lo;
                end else if (w_tmo_hit) begin
                    w_state_nxt = c_s_err;
                end
            end
            c_s_len_lo: begin
                if (w_accept) begin
                    w_state_nxt = w_len_bad ? c_s_err : c_s_data;
                end else if (w_tmo_hit) begin
                    w_state_nxt = c_s_err;
                end
            end
            c_s_data: begin
                if (w_accept) begin
                    if (w_word_done && w_last_word) begin
                        w_state_nxt = c_s_csum;
                    end
                end else if (w_tmo_hit) begin
                    w_state_nxt = c_s_err;
                end
            end
            c_s_csum: begin
                if (w_accept) begin
                    w_state_nxt = (w_csum_sum == 8'd0) ? c_s_run : c_s_err;
                end else if (w_tmo_hit) begin
                    w_state_nxt = c_s_err;
                end
            end
            default: begin
                w_state_nxt = c_s_idle;
            end
        endcase
        w_nxt_load = (w_state_nxt == c_s_len_hi) || (w_state_nxt == c_s_len_lo) ||
                     (w_state_nxt == c_s_data)   || (w_state_nxt == c_s_csum);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= c_s_idle;
            r_len_hi     <= 8'd0;
            r_len        <= '0;
            r_shift      <= 24'd0;
            r_byte_idx   <= 2'd0;
            r_csum       <= 8'd0;
            r_tmo        <= '0;
            in_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= 32'd0;
            cpu_rst      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            // Status outputs are a registered decode of the next state
            r_state  <= w_state_nxt;
            in_ready <= w_nxt_load;
            busy     <= w_nxt_load;
            done     <= (w_state_nxt == c_s_run);
            cpu_rst  <= (w_state_nxt == c_s_run);
            err      <= (w_state_nxt == c_s_err);
            imem_we  <= 1'b0;

            if (!w_in_load) begin
                if (start) begin
                    words_loaded <= '0;
                    r_byte_idx   <= 2'd0;
                    r_csum       <= 8'd0;
                    r_tmo        <= '0;
                end
            end else begin
                if (w_accept) begin
                    r_tmo <= '0;
                end else if (!w_tmo_hit) begin
                    r_tmo <= r_tmo + c_tmo_one;
                end

                if (w_accept) begin
                    case (r_state)
                        c_s_len_hi: begin
                            r_len_hi <= in_data;
                        end
                        c_s_len_lo: begin
                            r_len <= w_len[ADDR_W:0];
                        end
                        c_s_data: begin
                            r_shift    <= {r_shift[15:0], in_data};
                            r_csum     <= w_csum_sum;
                            r_byte_idx <= r_byte_idx + 2'd1;
                            if (w_word_done) begin
                                imem_we      <= 1'b1;
                                imem_addr    <= words_loaded[ADDR_W-1:0];
                                imem_wdata   <= {r_shift, in_data};
                                words_loaded <= w_wl_inc;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_boot_loader
// Description : Directed self-checking bench with a write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

    localparam int ADDR_W      = 8;
    localparam int TIMEOUT_CYC = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    int          checks = 0;
    int          errors = 0;
    string       phase  = "init";
    logic [39:0] exp_q[$];
    logic [7:0]  stream[$];
    logic [31:0] model_word;

    imem_boot_loader #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    // Advance one edge; every write strobe is matched against the scoreboard
    task automatic tick();
        logic [39:0] e;
        @(posedge clk);
        #1;
        if (imem_we) begin
            if (exp_q.size() == 0) begin
                chk("spurious_we", imem_we, 1'b0);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (imem_addr !== e[39:32]) begin
                    errors++;
                    $error("FAIL %s/we_addr observed=%0h expected=%0h", phase, imem_addr, e[39:32]);
                end
                checks++;
                if (imem_wdata !== e[31:0]) begin
                    errors++;
                    $error("FAIL %s/we_data observed=%0h expected=%0h", phase, imem_wdata, e[31:0]);
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) begin
            chk("ready_wait", in_ready, 1'b1);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Sends stream[first..last]; the reference model predicts each word write
    task automatic run_stream(input bit gap, input int first, input int last);
        int len;
        len = int'({stream[0], stream[1]});
        for (int i = first; i <= last; i++) begin
            if (i >= 2 && len != 0 && len <= 256 && i < 2 + 4 * len) begin
                model_word = {model_word[23:0], stream[i]};
                if (((i - 2) % 4) == 3) begin
                    exp_q.push_back({8'((i - 2) / 4), model_word});
                end
            end
            send_byte(stream[i]);
            if (gap) begin
                tick();
            end
        end
    endtask

    task automatic expect_status(input logic d, input logic e, input logic c,
                                 input logic b, input logic [ADDR_W:0] wl);
        checks++;
        if (done !== d) begin
            errors++;
            $error("FAIL %s/done observed=%0h expected=%0h", phase, done, d);
        end
        checks++;
        if (err !== e) begin
            errors++;
            $error("FAIL %s/err observed=%0h expected=%0h", phase, err, e);
        end
        checks++;
        if (cpu_rst !== c) begin
            errors++;
            $error("FAIL %s/cpu_rst observed=%0h expected=%0h", phase, cpu_rst, c);
        end
        checks++;
        if (busy !== b) begin
            errors++;
            $error("FAIL %s/busy observed=%0h expected=%0h", phase, busy, b);
        end
        checks++;
        if (words_loaded !== wl) begin
            errors++;
            $error("FAIL %s/words_loaded observed=%0h expected=%0h", phase, words_loaded, wl);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $error("FAIL %s/scoreboard_empty observed=%0d expected=0", phase, exp_q.size());
        end
    endtask

    task automatic set_basic_stream(input logic [7:0] csum);
        stream = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                  8'h8C, 8'h09, 8'h00, 8'h04, csum};
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  sum;
        logic [31:0] w;
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        phase = "reset";
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            start    = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            tick();
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("in_ready", in_ready, 1'b0);
        chk("imem_we", imem_we, 1'b0);
        chk("imem_addr", imem_addr, 8'h00);
        chk("imem_wdata", imem_wdata, 32'h0);
        expect_status(1'b0, 1'b0, 1'b0, 1'b0, 9'd0);
        rst = 1'b1;
        tick();

        phase = "good_load";
        pulse_start();
        chk("busy_after_start", busy, 1'b1);
        chk("ready_after_start", in_ready, 1'b1);
        set_basic_stream(8'h3A);
        run_stream(1'b0, 0, 10);
        expect_status(1'b1, 1'b0, 1'b1, 1'b0, 9'd2);
        chk("ready_in_run", in_ready, 1'b0);

        phase = "bad_csum";
        pulse_start();
        chk("cpu_rst_on_restart", cpu_rst, 1'b0);
        chk("done_on_restart", done, 1'b0);
        set_basic_stream(8'h3B);
        run_stream(1'b0, 0, 10);
        expect_status(1'b0, 1'b1, 1'b0, 1'b0, 9'd2);

        phase = "len_zero";
        pulse_start();
        stream = {8'h00, 8'h00};
        run_stream(1'b0, 0, 1);
        expect_status(1'b0, 1'b1, 1'b0, 1'b0, 9'd0);

        phase = "len_257";
        pulse_start();
        stream = {8'h01, 8'h01};
        run_stream(1'b0, 0, 1);
        expect_status(1'b0, 1'b1, 1'b0, 1'b0, 9'd0);

        phase = "len_256";
        pulse_start();
        stream = {8'h01, 8'h00};
        sum    = 8'h00;
        for (int k = 0; k < 256; k++) begin
            w = $urandom;
            for (int j = 3; j >= 0; j--) begin
                stream.push_back(w[8*j +: 8]);
                sum = sum + w[8*j +: 8];
            end
        end
        stream.push_back(8'h00 - sum);
        run_stream(1'b0, 0, stream.size() - 1);
        expect_status(1'b1, 1'b0, 1'b1, 1'b0, 9'd256);

        phase = "timeout";
        pulse_start();
        set_basic_stream(8'h3A);
        run_stream(1'b0, 0, 4);
        for (int i = 0; i < TIMEOUT_CYC - 1; i++) begin
            tick();
        end
        chk("err_before_limit", err, 1'b0);
        chk("busy_before_limit", busy, 1'b1);
        tick();
        expect_status(1'b0, 1'b1, 1'b0, 1'b0, 9'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        chk("no_partial_we", words_loaded, 9'd0);

        phase = "reload_after_timeout";
        pulse_start();
        run_stream(1'b0, 0, 10);
        expect_status(1'b1, 1'b0, 1'b1, 1'b0, 9'd2);

        phase = "reset_mid_data";
        pulse_start();
        run_stream(1'b0, 0, 3);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("in_ready", in_ready, 1'b0);
        chk("imem_addr", imem_addr, 8'h00);
        chk("imem_wdata", imem_wdata, 32'h0);
        expect_status(1'b0, 1'b0, 1'b0, 1'b0, 9'd0);
        tick();

        phase = "start_while_busy";
        pulse_start();
        run_stream(1'b0, 0, 5);
        pulse_start();
        chk("busy_kept", busy, 1'b1);
        chk("words_kept", words_loaded, 9'd1);
        run_stream(1'b0, 6, 10);
        expect_status(1'b1, 1'b0, 1'b1, 1'b0, 9'd2);

        phase = "gapped";
        pulse_start();
        run_stream(1'b1, 0, 10);
        expect_status(1'b1, 1'b0, 1'b1, 1'b0, 9'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream feeder for the single-cycle core's instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word to instruction memory at consecutive word addresses, then verifies a trailing checksum.
- Holds the core in reset until a good load completes; releases it only on a correct checksum.

Parameters:
ADDR_W, 8, instruction-memory word-address width (capacity 2^ADDR_W words)
TIMEOUT_CYC, 1000000, max idle cycles between accepted bytes during a load before abort

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-low reset
start  input  1  one-cycle pulse; begins a load from IDLE, RUN or ERR
in_valid  input  1  byte-stream valid
in_data  input  8  byte-stream data
in_ready  output  1  loader can accept a byte this cycle
imem_we  output  1  instruction-memory write strobe, one-cycle pulse per word
imem_addr  output  ADDR_W  word address for the write
imem_wdata  output  32  instruction word to write
cpu_rst  output  1  active-low reset to the core; 0 holds the core, 1 releases it
busy  output  1  load in progress
done  output  1  last load succeeded; core running
err  output  1  last load aborted
words_loaded  output  ADDR_W+1  number of words written in the current/last load

Behaviour:
- All state is updated on the rising clk edge. All outputs are registered.
- Reset (rst==0 at an edge): state=IDLE; in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=0, busy=0, done=0, err=0, words_loaded=0.
  - Applies from any state, including mid-load.
  - Words already written to instruction memory are not cleared.
- Byte acceptance: a byte is accepted at an edge where in_valid==1 and in_ready==1.
  - in_ready=1 in LEN_HI, LEN_LO, DATA and CSUM; 0 otherwise.
  - The loader never stalls inside those states; in_valid gaps are allowed.
- States:
  - IDLE:
    - start -> LEN_HI.
    - On entry to LEN_HI: busy=1, done=0, err=0, cpu_rst=0, words_loaded=0, byte index=0, checksum accumulator=0, timeout counter=0.
  - LEN_HI: accept byte as N[15:8] -> LEN_LO.
  - LEN_LO: accept byte as N[7:0].
    - If N==0 or N>2^ADDR_W -> ERR.
    - Otherwise -> DATA.
  - DATA:
    - Bytes arrive MSB first; byte index counts 0..3.
    - Each accepted data byte is added to the 8-bit checksum accumulator (mod 256). Length bytes are excluded.
    - On the edge accepting byte index 3:
      - imem_we=1 for exactly the following cycle.
      - imem_addr = current word index.
      - imem_wdata = assembled word.
      - words_loaded increments on that same edge.
    - After word N-1 is accepted -> CSUM.
  - CSUM: accept one byte C.
    - If (accumulator + C) mod 256 == 0 -> RUN.
    - Otherwise -> ERR.
  - RUN: done=1, cpu_rst=1, busy=0.
  - ERR: err=1, cpu_rst=0, busy=0, done=0.
- Restart and start handling:
  - start in RUN or ERR restarts the load, with the same entry actions as from IDLE. cpu_rst drops to 0 on that edge.
  - start in LEN_HI, LEN_LO, DATA or CSUM is ignored.
- Timeout:
  - Counter is active in LEN_HI..CSUM and clears on every accepted byte.
  - If it reaches TIMEOUT_CYC -> ERR on that edge.
  - Partial words are discarded; no imem_we is issued for them.
- Simultaneous events:
  - rst has priority over everything.
  - Timeout and byte acceptance on the same edge: the byte wins, and the counter clears.
- Address wrap: none. The N bound guarantees imem_addr never exceeds 2^ADDR_W-1.

Test Plan:
1. Reset: hold rst=0 for 3 edges with random in_valid/start -> all outputs at reset values and in_ready=0.
2. Good load, TIMEOUT_CYC=16: pulse start, then bytes 00 02 20 08 00 05 8C 09 00 04 3A.
   - imem_we pulses twice: addr 0 data 0x20080005, then addr 1 data 0x8C090004.
   - words_loaded=2, done=1, cpu_rst=1, busy=0, err=0.
3. Same stream with checksum byte 3B -> err=1, cpu_rst=0, done=0, words_loaded=2.
4. Length checks (ADDR_W=8):
   - Length 00 00 -> err=1 after the LEN_LO byte, no imem_we.
   - Length 01 01 -> err=1.
   - Length 01 00 with 256 words and correct checksum -> done=1, words_loaded=256.
5. Timeout, TIMEOUT_CYC=16:
   - Stop in_valid after the 3rd data byte -> err=1 exactly 16 edges after the last accepted byte, no imem_we for the partial word.
   - Then start plus stream from test 2 -> done=1.
6. Interrupted load and handshake gaps:
   - Drive rst=0 for one edge mid-DATA -> reset values the next cycle.
   - Drive start while busy -> ignored.
   - Stream from test 2 with in_valid toggling 1/0 every cycle -> same writes and done=1.
